// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants, types and pulse-width helper for servo_sched
package servo_pkg;

   localparam int BASE_CLKS  = 27500;
   localparam int STEP_SHIFT = 6;

   typedef logic [7:0] duty_t;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP
   } state_t;

   // Width in clocks of one servo pulse for the given duty code.
   function automatic logic [15:0] pulse_width(input duty_t duty, input int base, input int shift);
      return 16'(base) + (16'(duty) << shift);
   endfunction

endpackage

// File: rtl/servo_slew.sv
// rtl/servo_slew.sv - next active duty, stepping toward the target by at most STEP
module servo_slew
   import servo_pkg::*;
#(
   parameter int STEP = 4
) (
   input  duty_t target_i,
   input  duty_t cur_i,
   output duty_t next_o
);

   localparam duty_t STEP_D = duty_t'((STEP > 255) ? 255 : STEP);

   duty_t diff;

   always_comb begin
      next_o = target_i;
      diff   = '0;
      if (target_i > cur_i) begin
         diff = target_i - cur_i;
         if (diff > STEP_D) next_o = cur_i + STEP_D;
      end else if (target_i < cur_i) begin
         diff = cur_i - target_i;
         if (diff > STEP_D) next_o = cur_i - STEP_D;
      end
   end

endmodule

// File: rtl/servo_sched.sv
// rtl/servo_sched.sv - multi-channel servo frame scheduler, one shared pulse timer
// Optional slew limiting of committed duties when SERVO_SLEW_EN is defined.
module servo_sched
   import servo_pkg::*;
#(
   parameter int CLK_HZ      = 25000000,
   parameter int FRAME_HZ    = 50,
   parameter int N_CH        = 4,
   parameter int SLEW_STEP   = 4,
   parameter int PULSE_BASE  = BASE_CLKS,
   parameter int PULSE_SHIFT = STEP_SHIFT,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [CH_W-1:0] wr_ch,
   input  logic [7:0]      wr_duty,
   output logic [N_CH-1:0] servo_out,
   output logic            frame_start,
   output logic [CH_W-1:0] cur_ch
);

   localparam int FRAME_CLKS = CLK_HZ / FRAME_HZ;
   localparam int MAX_W      = PULSE_BASE + (255 << PULSE_SHIFT);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

   if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
      $error("servo_sched: N_CH must be 1..8");
   end
   if (N_CH * (MAX_W + 1) >= FRAME_CLKS) begin : g_bad_frame
      $error("servo_sched: all channel pulses do not fit in one frame");
   end
   if (FRAME_CLKS > (1 << 19) || MAX_W > 65535) begin : g_bad_width
      $error("servo_sched: frame or pulse counter overflow");
   end
   if (SLEW_STEP < 1) begin : g_bad_slew
      $error("servo_sched: SLEW_STEP must be at least 1");
   end

   state_t          state_q;
   logic [18:0]     fcnt_q;
   logic [CH_W-1:0] ch_q;
   logic [CH_W-1:0] ch_nxt;
   logic [15:0]     wcnt_q;
   logic [15:0]     width_cur;
   logic [N_CH-1:0] servo_out_q;
   logic [CH_W-1:0] cur_ch_q;
   logic            fs;
   duty_t           shadow_q    [N_CH];
   duty_t           active_q    [N_CH];
   duty_t           next_active [N_CH];

   assign fs          = en && (fcnt_q == '0) && !rst;
   assign frame_start = fs;
   assign wr_ready    = !rst;
   assign servo_out   = servo_out_q;
   assign cur_ch      = cur_ch_q;
   assign ch_nxt      = ch_q + 1'b1;
   assign width_cur   = pulse_width(active_q[ch_q], PULSE_BASE, PULSE_SHIFT);

`ifdef SERVO_SLEW_EN
   for (genvar g = 0; g < N_CH; g++) begin : g_slew
      servo_slew #(
         .STEP(SLEW_STEP)
      ) u_slew (
         .target_i(shadow_q[g]),
         .cur_i   (active_q[g]),
         .next_o  (next_active[g])
      );
   end
`else
   always_comb begin
      for (int i = 0; i < N_CH; i++) next_active[i] = shadow_q[i];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt_q <= '0;
      end else if (!en || fcnt_q == 19'(FRAME_CLKS - 1)) begin
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + 19'd1;
      end
   end

   // Commit samples the pre-edge shadow, so a write on the commit edge waits a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            shadow_q[i] <= 8'd128;
            active_q[i] <= 8'd128;
         end
      end else begin
         if (state_q == IDLE && fs) begin
            for (int i = 0; i < N_CH; i++) active_q[i] <= next_active[i];
         end
         if (wr_valid && int'(wr_ch) < N_CH) shadow_q[wr_ch] <= wr_duty;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         wcnt_q      <= '0;
         servo_out_q <= '0;
         cur_ch_q    <= '0;
      end else if (!en) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         wcnt_q      <= '0;
         servo_out_q <= '0;
         cur_ch_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fs) begin
                  state_q     <= PULSE;
                  ch_q        <= '0;
                  wcnt_q      <= '0;
                  servo_out_q <= N_CH'(1);
                  cur_ch_q    <= '0;
               end
            end
            PULSE: begin
               if (wcnt_q == width_cur - 16'd1) begin
                  state_q     <= GAP;
                  servo_out_q <= '0;
                  cur_ch_q    <= '0;
               end else begin
                  wcnt_q <= wcnt_q + 16'd1;
               end
            end
            GAP: begin
               if (ch_q == LAST_CH) begin
                  state_q <= IDLE;
                  ch_q    <= '0;
               end else begin
                  state_q     <= PULSE;
                  ch_q        <= ch_nxt;
                  wcnt_q      <= '0;
                  servo_out_q <= N_CH'(1) << ch_nxt;
                  cur_ch_q    <= ch_nxt;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
